alu_sequencer: RTL

- Multi-T-state controller that drives the 28-bit control-store word (CS_bus) consumed by the ALU and its surrounding register file.
- Accepts one arithmetic/logic instruction per valid/ready handshake and sequences it through fixed T-states:
  - operand onto ibus plus ALU op strobe (Z/flag load);
  - Z onto obus plus accumulator load.
- Sits between the instruction decoder and the datapath; it is the only driver of the ALU op bits, z_out and flag_out.

---
 rtl/alu_sequencer.sv | 125 ++++++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: steps one ALU instruction at a time through its T-states and drives the control-store word.
// Defining ALU_SEQ_FLAG_WB_EN adds a flag write-back T-state (FWB) after WB.
module alu_sequencer #(
   parameter int SZ           = 28,
   parameter int ACC_IN       = 6,
   parameter int SRC_OUT_BASE = 8,
   parameter int IMM_OUT      = 16,
   parameter int FLAG_IN      = 24
) (
   input  logic          CLK,
   input  logic          RST_N,
   input  logic          op_valid,
   output logic          op_ready,
   input  logic [2:0]    op_code,
   input  logic [2:0]    src_sel,
   input  logic          imm_mode,
   output logic [SZ-1:0] CS_bus,
   output logic          busy,
   output logic          done,
   output logic          err
);

   localparam int Z_OUT    = 25;
   localparam int FLAG_OUT = 26;
   localparam logic [SZ-1:0] ONE = {{(SZ-1){1'b0}}, 1'b1};

`ifdef ALU_SEQ_FLAG_WB_EN
   typedef enum logic [1:0] {IDLE, EXEC, WB, FWB} state_t;
   localparam logic [SZ-1:0] DRIVE_MASK = '1;
`else
   typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;
   // The status-register load bit belongs to the flag write-back feature only.
   localparam logic [SZ-1:0] DRIVE_MASK = ~(ONE << FLAG_IN);
`endif

   state_t     state;
   logic [2:0] op_q;
   logic       take;
   logic       legal;

   assign take  = op_valid & op_ready;
   assign legal = (op_code <= 3'd5);

   function automatic logic [SZ-1:0] exec_word(input logic [2:0] op, input logic [2:0] src,
                                               input logic imm);
      logic [SZ-1:0] w;
      w = '0;
      case (op)
         3'd0:    w[0]   = 1'b1;
         3'd1:    w[2]   = 1'b1;
         3'd2:    w[2:1] = 2'b11;
         3'd3:    w[3]   = 1'b1;
         3'd4:    w[4]   = 1'b1;
         3'd5:    w[5]   = 1'b1;
         default: w      = '0;
      endcase
      if (imm) w = w | (ONE << IMM_OUT);
      else     w = w | (ONE << (SRC_OUT_BASE + int'(src)));
      return w & DRIVE_MASK;
   endfunction

   // CMP only sets flags, so its write-back cycle leaves the accumulator alone.
   function automatic logic [SZ-1:0] wb_word(input logic [2:0] op);
      logic [SZ-1:0] w;
      w = '0;
      if (op != 3'd2) w = (ONE << Z_OUT) | (ONE << ACC_IN);
      return w & DRIVE_MASK;
   endfunction

   always_ff @(posedge CLK) begin
      if (take && legal) op_q <= op_code;
   end

   // op_ready is raised in the final T-state so a held op_valid is taken on the edge leaving it.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state    <= IDLE;
         CS_bus   <= '0;
         op_ready <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         if (take && legal) begin
            state    <= EXEC;
            CS_bus   <= exec_word(op_code, src_sel, imm_mode);
            op_ready <= 1'b0;
            busy     <= 1'b1;
         end else begin
            case (state)
               EXEC: begin
                  state  <= WB;
                  CS_bus <= wb_word(op_q);
                  busy   <= 1'b1;
`ifdef ALU_SEQ_FLAG_WB_EN
                  op_ready <= 1'b0;
`else
                  op_ready <= 1'b1;
                  done     <= 1'b1;
`endif
               end
`ifdef ALU_SEQ_FLAG_WB_EN
               WB: begin
                  state    <= FWB;
                  CS_bus   <= (ONE << FLAG_OUT) | (ONE << FLAG_IN);
                  op_ready <= 1'b1;
                  busy     <= 1'b1;
                  done     <= 1'b1;
               end
`endif
               default: begin
                  state    <= IDLE;
                  CS_bus   <= '0;
                  op_ready <= 1'b1;
                  busy     <= 1'b0;
                  err      <= take;
               end
            endcase
         end
      end
   end

endmodule
